// File: rtl/pm_pkg.sv
// pm_pkg: shared FSM encoding and default sizing for the period meter.
package pm_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_e;
    localparam int          CNT_W_DEF       = 32;
    localparam int unsigned TIMEOUT_DEF     = 100_000_000;
    localparam int          SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: synchronizes sig_i and flags rising/falling edges of the synchronized level.
module sync_edge
    import pm_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES:0]   live_q, live_d;
    logic                   p_q, p_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
        live_d = {live_q[SYNC_STAGES-1:0], 1'b1};
        p_d    = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            live_q <= '0;
            p_q    <= 1'b0;
        end else begin
            sync_q <= sync_d;
            live_q <= live_d;
            p_q    <= p_d;
        end
    end

    // Edges are masked until p holds a real sample, so a level already high at reset is not a rise
    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = live_q[SYNC_STAGES] & s_o & ~p_q;
    assign fall_o = live_q[SYNC_STAGES] & ~s_o & p_q;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures high time, low time and period of an async square wave in clk_i cycles.
// Publishes one result per rising-to-rising period and flags a stalled input.
module period_meter
    import pm_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
    parameter int          SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sig_i,
    output logic             meas_valid_o,
    output logic [CNT_W-1:0] high_cnt_o,
    output logic [CNT_W-1:0] low_cnt_o,
    output logic [CNT_W:0]   period_o,
    output logic             stuck_o
);
    localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d, idle_q, idle_d;
    logic [CNT_W-1:0] high_q, high_d, low_q, low_d;
    logic [CNT_W:0]   period_q, period_d;
    logic             valid_q, valid_d, stuck_q, stuck_d;
    logic             s, rise, fall;
    logic [CNT_W-1:0] hcnt_inc, lcnt_inc, idle_inc;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sig_i (sig_i),
        .s_o   (s),
        .rise_o(rise),
        .fall_o(fall)
    );

    assign hcnt_inc = hcnt_q + ONE;
    assign lcnt_inc = lcnt_q + ONE;
    assign idle_inc = idle_q + ONE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            lcnt_q   <= '0;
            idle_q   <= '0;
            high_q   <= '0;
            low_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            idle_q   <= idle_d;
            high_q   <= high_d;
            low_q    <= low_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = rise ? HIGH : IDLE;
            HIGH:    state_d = fall ? LOW : (hcnt_inc == TO) ? IDLE : HIGH;
            LOW:     state_d = rise ? HIGH : (lcnt_inc == TO) ? IDLE : LOW;
            default: state_d = IDLE;
        endcase
    end

    // Counts include the edge cycle itself, so a level of k synchronized cycles reads as k
    always_comb begin
        hcnt_d   = hcnt_q;
        lcnt_d   = lcnt_q;
        idle_d   = idle_q;
        high_d   = high_q;
        low_d    = low_q;
        period_d = period_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    hcnt_d  = ONE;
                    idle_d  = '0;
                    stuck_d = 1'b0;
                end else begin
                    idle_d  = (idle_q == TO) ? idle_q : idle_inc;
                    stuck_d = stuck_q | (idle_inc == TO);
                end
            end
            HIGH: begin
                if (fall) begin
                    lcnt_d = ONE;
                end else begin
                    hcnt_d  = hcnt_inc;
                    stuck_d = stuck_q | (hcnt_inc == TO);
                end
            end
            LOW: begin
                if (rise) begin
                    valid_d  = 1'b1;
                    high_d   = hcnt_q;
                    low_d    = lcnt_q;
                    period_d = {1'b0, hcnt_q} + {1'b0, lcnt_q};
                    hcnt_d   = ONE;
                end else begin
                    lcnt_d  = lcnt_inc;
                    stuck_d = stuck_q | (lcnt_inc == TO);
                end
            end
            default: ;
        endcase
    end

    assign meas_valid_o = valid_q;
    assign high_cnt_o   = high_q;
    assign low_cnt_o    = low_q;
    assign period_o     = period_q;
    assign stuck_o      = stuck_q;
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed waves with a scoreboard of expected results and valid-pulse cycles.
module tb_period_meter;
    localparam int CW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          sig_i = 1'b0;
    logic          meas_valid_o, stuck_o;
    logic [CW-1:0] high_cnt_o, low_cnt_o;
    logic [CW:0]   period_o;

    typedef struct {
        int h;
        int l;
        int p;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   ph = 0;
    int   pl = 0;
    bit   armed = 1'b0;

    period_meter #(.CNT_W(CW), .TIMEOUT(20), .SYNC_STAGES(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sig_i       (sig_i),
        .meas_valid_o(meas_valid_o),
        .high_cnt_o  (high_cnt_o),
        .low_cnt_o   (low_cnt_o),
        .period_o    (period_o),
        .stuck_o     (stuck_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // A rise that closes a complete period yields a valid SYNC_STAGES+1 cycles later
    task automatic push_if_armed();
        exp_t e;
        if (armed) begin
            e.h = ph;
            e.l = pl;
            e.p = ph + pl;
            e.cyc = cyc + 3;
            q.push_back(e);
        end
    endtask

    task automatic period(input int h, input int l);
        push_if_armed();
        sig_i = 1'b1;
        repeat (h) @(negedge clk_i);
        sig_i = 1'b0;
        repeat (l) @(negedge clk_i);
        armed = 1'b1;
        ph = h;
        pl = l;
    endtask

    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (meas_valid_o) begin
            chk("valid expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("high_cnt", high_cnt_o, e.h);
                chk("low_cnt", low_cnt_o, e.l);
                chk("period", period_o, e.p);
                chk("valid cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst valid", meas_valid_o, 0);
        chk("rst high", high_cnt_o, 0);
        chk("rst low", low_cnt_o, 0);
        chk("rst period", period_o, 0);
        chk("rst stuck", stuck_o, 0);
        // No edges: stuck exactly TIMEOUT cycles after release
        rst_i = 1'b0;
        repeat (19) @(negedge clk_i);
        chk("idle stuck early", stuck_o, 0);
        @(negedge clk_i);
        chk("idle stuck", stuck_o, 1);
        chk("idle valid", meas_valid_o, 0);
        chk("idle period", period_o, 0);
        repeat (3) @(negedge clk_i);
        repeat (4) period(5, 6);
        chk("hold high", high_cnt_o, 5);
        chk("hold period", period_o, 11);
        chk("stuck after rise", stuck_o, 0);
        repeat (6) period(1, 3);
        repeat (2) period(5, 6);
        // Held high past TIMEOUT: stuck when hcnt reaches 20, truncated period discarded
        push_if_armed();
        sig_i = 1'b1;
        repeat (21) @(negedge clk_i);
        chk("hcnt stuck early", stuck_o, 0);
        @(negedge clk_i);
        chk("hcnt stuck", stuck_o, 1);
        repeat (3) @(negedge clk_i);
        sig_i = 1'b0;
        armed = 1'b0;
        repeat (6) @(negedge clk_i);
        sig_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("stuck before rise", stuck_o, 1);
        @(negedge clk_i);
        chk("stuck cleared", stuck_o, 0);
        repeat (2) @(negedge clk_i);
        sig_i = 1'b0;
        repeat (6) @(negedge clk_i);
        armed = 1'b1;
        ph = 5;
        pl = 6;
        repeat (2) period(5, 6);
        // Reset in the middle of LOW
        push_if_armed();
        sig_i = 1'b1;
        repeat (5) @(negedge clk_i);
        sig_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("mid rst valid", meas_valid_o, 0);
        chk("mid rst high", high_cnt_o, 0);
        chk("mid rst low", low_cnt_o, 0);
        chk("mid rst period", period_o, 0);
        chk("mid rst stuck", stuck_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        armed = 1'b0;
        repeat (4) @(negedge clk_i);
        repeat (3) period(5, 6);
        // Reset released while the input is already high
        sig_i = 1'b1;
        #2 rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        armed = 1'b0;
        repeat (4) @(negedge clk_i);
        sig_i = 1'b0;
        repeat (3) @(negedge clk_i);
        repeat (2) period(7, 3);
        push_if_armed();
        sig_i = 1'b1;
        repeat (6) @(negedge clk_i);
        chk("scoreboard drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
